// File: rtl/adder_share_arb_pkg.sv
// adder_share_arb_pkg: shared constants, FSM state type and round-robin pick function
package adder_share_arb_pkg;

    localparam int ADD_W       = 32;
    localparam int ARB_MAX_REQ = 8;
    localparam int ARB_IDW     = $clog2(ARB_MAX_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // First set bit of valid at or after ptr, wrapping at nreq; returns ptr when nothing is valid.
    function automatic logic [ARB_IDW-1:0] rr_pick(
        input logic [ARB_MAX_REQ-1:0] valid,
        input logic [ARB_IDW-1:0]     ptr,
        input int                     nreq
    );
        logic found;
        int   j;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < ARB_MAX_REQ; k++) begin
            j = (int'(ptr) + k) % nreq;
            if (k < nreq && !found && valid[j]) begin
                rr_pick = ARB_IDW'(j);
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/adder_share_arb_rec_dub.sv
// rec_dub: 32-bit Kogge-Stone parallel-prefix adder, purely combinational
module rec_dub
    import adder_share_arb_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    localparam int LVLS = $clog2(ADD_W);

    logic [ADD_W-1:0] g, p, gn, pn;

    // After the last level g[i] is the carry out of bit i with no carry in.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gn = g;
        pn = p;
        for (int l = 0; l < LVLS; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i < ADD_W; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        sum  = (a ^ b) ^ {g[ADD_W-2:0], 1'b0};
        cout = g[ADD_W-1];
    end

endmodule

// File: rtl/adder_share_arb_rr_arb.sv
// rr_arb: combinational round-robin picker producing one-hot grant, index and any-valid
module rr_arb
    import adder_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [ARB_MAX_REQ-1:0] valid_pad;
    logic [ARB_IDW-1:0]     pick;

    assign valid_pad = ARB_MAX_REQ'(valid);
    assign pick      = rr_pick(valid_pad, ARB_IDW'(ptr), NREQ);
    assign idx       = IDW'(pick);
    assign any       = |valid;
    assign grant     = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one 32-bit adder among NREQ requesters,
// with a single registered, ID-tagged response port and an accepted-request counter.
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int W    = ADD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [15:0]       busy_cnt
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_sum_q, rsp_sum_d;
    logic            rsp_cout_q, rsp_cout_d;
    logic [15:0]     busy_cnt_q, busy_cnt_d;
    logic            can_accept, xfer;
    logic [NREQ-1:0] arb_valid;
    logic [IDW-1:0]  gnt_idx;
    logic [W-1:0]    add_a, add_b, add_sum;
    logic            add_cout;

    // rst_n masks the grant so req_ready stays low for the whole reset window.
    assign can_accept = (state_q == EMPTY) || rsp_ready;
    assign arb_valid  = (rst_n && can_accept) ? req_valid : '0;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid (arb_valid),
        .ptr   (ptr_q),
        .grant (req_ready),
        .idx   (gnt_idx),
        .any   (xfer)
    );

    assign add_a = req_a[gnt_idx*W +: W];
    assign add_b = req_b[gnt_idx*W +: W];

    rec_dub u_add (
        .a    (add_a),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        busy_cnt_d = busy_cnt_q;
        if (xfer) begin
            state_d    = FULL;
            rsp_id_d   = gnt_idx;
            rsp_sum_d  = add_sum;
            rsp_cout_d = add_cout;
            ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            busy_cnt_d = (busy_cnt_q == 16'hFFFF) ? busy_cnt_q : busy_cnt_q + 16'd1;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed vectors plus a model-checked random soak for adder_share_arb
module tb_adder_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              rsp_valid, rsp_ready, rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic [15:0]       busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    adder_share_arb #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    logic [W-1:0] ea [NREQ];
    logic [W-1:0] eb [NREQ];
    logic [32:0]  es [NREQ];

    int          m_ptr, m_id, m_busy, g;
    logic        m_full;
    logic [32:0] m_sum;
    logic [W-1:0] sa, sb;

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        ea[0] = 32'h1234_5678; eb[0] = 32'h1111_1111; es[0] = 33'h0_2345_6789;
        ea[1] = 32'h8000_0000; eb[1] = 32'h8000_0000; es[1] = 33'h1_0000_0000;
        ea[2] = 32'hFFFF_FFFF; eb[2] = 32'hFFFF_FFFF; es[2] = 33'h1_FFFF_FFFE;
        ea[3] = 32'hDEAD_BEEF; eb[3] = 32'h0000_0001; es[3] = 33'h0_DEAD_BEF0;
        for (int i = 0; i < NREQ; i++) set_op(i, ea[i], eb[i]);
        repeat (3) step();
        req_valid = 4'b1111;
        #1;
        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_id", rsp_id, 0);
        check("rst_busy", busy_cnt, 0);
        check("rst_ready", req_ready, 0);
        req_valid = '0;
        @(negedge clk) rst_n = 1'b1;
        step();

        // Fairness: all valid from ptr 0 -> 0,1,2,3,0.
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ready", req_ready, 64'(1) << (k % 4));
            step();
            check("rr_valid", rsp_valid, 1);
            check("rr_id", rsp_id, 64'(k % 4));
            check("rr_sum", {rsp_cout, rsp_sum}, es[k % 4]);
        end
        check("rr_busy", busy_cnt, 5);
        req_valid = '0;
        step();
        check("drain_valid", rsp_valid, 0);

        // Single requester 2 with carry out; ptr is 1 here.
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid = 4'b0100;
        #1;
        check("single_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        check("single_valid", rsp_valid, 1);
        check("single_sum", rsp_sum, 0);
        check("single_cout", rsp_cout, 1);
        check("single_id", rsp_id, 2);
        check("single_busy", busy_cnt, 6);

        // Backpressure for 5 cycles, then drain + grant on the same edge (ptr is 3).
        rsp_ready = 1'b0; req_valid = 4'b1111;
        repeat (5) begin
            #1;
            check("bp_ready", req_ready, 0);
            step();
            check("bp_valid", rsp_valid, 1);
            check("bp_hold", {rsp_id, rsp_cout, rsp_sum}, {2'd2, 1'b1, 32'h0});
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 4'b1000);
        step();
        check("bp_id", rsp_id, 3);
        check("bp_sum", {rsp_cout, rsp_sum}, es[3]);
        check("bp_busy", busy_cnt, 7);

        // Move ptr to 3 via a grant to 2, then wrap and skip with valid 0101.
        req_valid = 4'b0100;
        #1;
        check("pre_wrap_ready", req_ready, 4'b0100);
        step();
        req_valid = 4'b0101;
        #1;
        check("wrap_ready0", req_ready, 4'b0001);
        step();
        check("wrap_id0", rsp_id, 0);
        check("wrap_sum0", {rsp_cout, rsp_sum}, es[0]);
        #1;
        check("wrap_ready2", req_ready, 4'b0100);
        step();
        check("wrap_id2", rsp_id, 2);
        check("wrap_busy", busy_cnt, 10);

        // Reset while FULL.
        req_valid = '0; rsp_ready = 1'b0;
        step();
        check("pre_rst_full", rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", rsp_valid, 0);
        check("arst_busy", busy_cnt, 0);
        check("arst_regs", {rsp_id, rsp_cout, rsp_sum}, 0);
        req_valid = 4'b1010;
        #1;
        check("arst_ready", req_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("post_rst_ready", req_ready, 4'b0010);
        step();
        check("post_rst_id", rsp_id, 1);
        check("post_rst_sum", {rsp_cout, rsp_sum}, es[1]);
        check("post_rst_busy", busy_cnt, 1);

        // Random soak against a reference model.
        req_valid = '0;
        rst_n = 1'b0;
        step();
        @(negedge clk) rst_n = 1'b1;
        step();
        m_ptr = 0; m_full = 1'b0; m_id = 0; m_busy = 0; m_sum = '0;
        for (int n = 0; n < 3000; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) set_op(i, $urandom, (n % 7 == 0) ? 32'hFFFF_FFFF : $urandom);
            #1;
            g = -1;
            if (!m_full || rsp_ready)
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            check("soak_ready", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
            if (g >= 0) begin
                sa = req_a[g*W +: W];
                sb = req_b[g*W +: W];
            end
            step();
            if (g >= 0) begin
                m_full = 1'b1;
                m_id   = g;
                m_sum  = {1'b0, sa} + {1'b0, sb};
                m_ptr  = (g + 1) % NREQ;
                m_busy++;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
            check("soak_valid", rsp_valid, m_full);
            if (m_full) begin
                check("soak_id", rsp_id, 64'(m_id));
                check("soak_sum", {rsp_cout, rsp_sum}, m_sum);
            end
            check("soak_busy", busy_cnt, 64'(m_busy));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
